// File: rtl/stage_sequencer_pkg.sv
// Shared types and defaults for the one-hot stage sequencer.
package stage_sequencer_pkg;

  typedef enum logic {
    RUN,
    HALTED
  } seq_state_e;

  localparam int NUM_STAGES_DEFAULT = 7;
  localparam int DECODE_IDX_DEFAULT = 1;
  localparam int CNT_W_DEFAULT      = 32;

endpackage

// File: rtl/stage_sequencer_next_stage_finder.sv
// Finds the lowest unskipped stage above the current one-hot stage;
// flags a wrap back to stage 0 when no such stage exists.
module next_stage_finder #(
  parameter int N = 7
) (
  input  logic [N-1:0] cur,
  input  logic [N-1:0] skip,
  output logic [N-1:0] nxt,
  output logic         wrap
);

  logic seen;
  logic found;

  always_comb begin
    nxt   = '0;
    seen  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (seen && !skip[i] && !found) begin
        nxt[i] = 1'b1;
        found  = 1'b1;
      end
      if (cur[i]) begin
        seen = 1'b1;
      end
    end
    wrap = !found;
    if (!found) begin
      nxt = N'(1);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// One-hot instruction stage sequencer with decode-time stage skipping,
// stall/flush control, retire counter and halt.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int DECODE_IDX = DECODE_IDX_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NUM_STAGES-1:0] skip_mask,
  input  logic                  halt,
  output logic [NUM_STAGES-1:0] stage,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      retired_count,
  output logic                  halted
);

  localparam logic [NUM_STAGES-1:0] LOW_MASK =
    NUM_STAGES'((1 << (DECODE_IDX + 1)) - 1);

  seq_state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  in_decode;
  logic [NUM_STAGES-1:0] eff_mask;
  logic [NUM_STAGES-1:0] nxt;
  logic                  wrap;

  // Leaving decode uses this cycle's skip request, not the old latch.
  assign in_decode = stage_q[DECODE_IDX];
  assign eff_mask  = in_decode ? (skip_mask & ~LOW_MASK) : mask_q;

  next_stage_finder #(
    .N(NUM_STAGES)
  ) u_finder (
    .cur (stage_q),
    .skip(eff_mask),
    .nxt (nxt),
    .wrap(wrap)
  );

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    mask_d     = mask_q;
    count_d    = count_q;
    instr_done = 1'b0;
    if (state_q == RUN) begin
      if (flush) begin
        stage_d = NUM_STAGES'(1);
        mask_d  = '0;
      end else if (!stall) begin
        if (wrap) begin
          instr_done = 1'b1;
          count_d    = count_q + 1'b1;
          mask_d     = '0;
          if (halt) begin
            state_d = HALTED;
            stage_d = '0;
          end else begin
            stage_d = nxt;
          end
        end else begin
          stage_d = nxt;
          mask_d  = eff_mask;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      stage_q <= NUM_STAGES'(1);
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign stage         = stage_q;
  assign retired_count = count_q;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed scoreboard bench for stage_sequencer (7 stages, decode 1, 4-bit count).
module tb_stage_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       stall;
  logic       flush;
  logic [6:0] skip_mask;
  logic       halt;
  logic [6:0] stage;
  logic       instr_done;
  logic [3:0] retired_count;
  logic       halted;

  typedef struct {
    logic [6:0] stage;
    logic       done;
    logic [3:0] cnt;
    logic       halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drv_done = 1'b0;

  stage_sequencer #(
    .NUM_STAGES(7),
    .DECODE_IDX(1),
    .CNT_W     (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .skip_mask    (skip_mask),
    .halt         (halt),
    .stage        (stage),
    .instr_done   (instr_done),
    .retired_count(retired_count),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    stall     = 1'b1;
    flush     = 1'b1;
    halt      = 1'b1;
    skip_mask = 7'h7f;
  endtask

  task automatic step(input logic st, input logic fl, input logic hl,
                      input logic [6:0] sk, input logic [6:0] es,
                      input logic ed, input logic [3:0] ec,
                      input logic eh);
    exp_t e;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    stall     = st;
    flush     = fl;
    halt      = hl;
    skip_mask = sk;
    e.stage   = es;
    e.done    = ed;
    e.cnt     = ec;
    e.halted  = eh;
    exp_q.push_back(e);
  endtask

  // Monitor: compare one expected entry per cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (stage !== e.stage || instr_done !== e.done ||
            retired_count !== e.cnt || halted !== e.halted) begin
          n_fail++;
          $display("FAIL chk%0d got stage=%b done=%b cnt=%0d halted=%b want stage=%b done=%b cnt=%0d halted=%b",
                   n_tests, stage, instr_done, retired_count, halted,
                   e.stage, e.done, e.cnt, e.halted);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] s2 [5];
    s2 = '{7'd1, 7'd2, 7'd4, 7'd32, 7'd64};
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    halt  = 1'b0;
    skip_mask = '0;

    // Plain instruction from reset.
    do_reset();
    for (int i = 0; i < 7; i++)
      step(0, 0, 0, 7'd0, 7'(1 << i), i == 6, 4'd0, 0);

    // Skip stages 3 and 4.
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 7'b0011000, s2[i], i == 4, 4'd1, 0);

    // Stall 3 cycles in stage 8, then flush with stall in stage 16.
    step(0, 0, 0, 7'd0, 7'd1, 0, 4'd2, 0);
    step(0, 0, 0, 7'd0, 7'd2, 0, 4'd2, 0);
    step(0, 0, 0, 7'd0, 7'd4, 0, 4'd2, 0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 7'd0, 7'd8, 0, 4'd2, 0);
    step(0, 0, 0, 7'd0, 7'd8, 0, 4'd2, 0);
    step(1, 1, 0, 7'd0, 7'd16, 0, 4'd2, 0);

    // Retire straight from decode; counter wraps 15 -> 0.
    for (int i = 2; i < 16; i++) begin
      step(0, 0, 0, 7'b1111100, 7'd1, 0, 4'(i), 0);
      step(0, 0, 0, 7'b1111100, 7'd2, 1, 4'(i), 0);
    end

    // halt is ignored mid-instruction, taken at retire.
    step(0, 0, 0, 7'd0, 7'd1, 0, 4'd0, 0);
    step(0, 0, 0, 7'd0, 7'd2, 0, 4'd0, 0);
    step(0, 0, 1, 7'd0, 7'd4, 0, 4'd0, 0);
    step(0, 0, 0, 7'd0, 7'd8, 0, 4'd0, 0);
    step(0, 0, 0, 7'd0, 7'd16, 0, 4'd0, 0);
    step(0, 0, 0, 7'd0, 7'd32, 0, 4'd0, 0);
    step(0, 0, 1, 7'd0, 7'd64, 1, 4'd0, 0);
    for (int i = 0; i < 10; i++)
      step(i[0], i[1], 1, 7'h7f, 7'd0, 0, 4'd1, 1);

    // Reset out of HALTED, then reset mid-stall.
    do_reset();
    step(0, 0, 0, 7'd0, 7'd1, 0, 4'd0, 0);
    step(0, 0, 0, 7'd0, 7'd2, 0, 4'd0, 0);
    step(1, 0, 0, 7'd0, 7'd4, 0, 4'd0, 0);
    do_reset();
    step(0, 0, 0, 7'd0, 7'd1, 0, 4'd0, 0);
    step(0, 0, 0, 7'd0, 7'd2, 0, 4'd0, 0);

    @(negedge clock);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
